// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope: steps an accumulator on the sample strobe
// and scales the signed oscillator sample by the top ENV_BITS of that accumulator.
module adsr_envelope #(
  parameter int DATA_BITS = 12,
  parameter int ENV_BITS  = 8,
  parameter int ACC_BITS  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        gate,
  input  logic [ACC_BITS-1:0]         attack_rate,
  input  logic [ACC_BITS-1:0]         decay_rate,
  input  logic [ACC_BITS-1:0]         release_rate,
  input  logic [ENV_BITS-1:0]         sustain_level,
  input  logic signed [DATA_BITS-1:0] din,
  output logic signed [DATA_BITS-1:0] dout,
  output logic [ENV_BITS-1:0]         env_out,
  output logic [2:0]                  state_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int PAD_BITS  = ACC_BITS - ENV_BITS;
  localparam int PROD_BITS = DATA_BITS + ENV_BITS + 1;
  localparam logic [ACC_BITS:0] ACC_MAX = {1'b0, {ACC_BITS{1'b1}}};

  state_t                        state_q, state_d;
  logic [ACC_BITS-1:0]           acc_q, acc_d;
  logic                          gate_q, gate_d;
  logic signed [DATA_BITS-1:0]   dout_q, dout_d;

  logic                          rise, fall;
  logic [ACC_BITS-1:0]           sus_acc;
  logic [ACC_BITS:0]             sum_att, diff_dec, diff_rel;
  logic [ENV_BITS-1:0]           env;
  logic signed [ENV_BITS:0]      gain;
  logic signed [PROD_BITS-1:0]   din_ext, gain_ext, product;

  assign sus_acc  = {sustain_level, {PAD_BITS{1'b0}}};
  assign env      = acc_q[ACC_BITS-1 -: ENV_BITS];
  assign rise     = gate & ~gate_q;
  assign fall     = ~gate & gate_q;

  // One extra bit so overflow/underflow is visible instead of wrapping.
  assign sum_att  = {1'b0, acc_q} + {1'b0, attack_rate};
  assign diff_dec = {1'b0, acc_q} - {1'b0, decay_rate};
  assign diff_rel = {1'b0, acc_q} - {1'b0, release_rate};

  // Gain is the unsigned envelope as a non-negative signed value (< 1.0).
  assign gain     = {1'b0, env};
  assign din_ext  = PROD_BITS'(din);
  assign gain_ext = PROD_BITS'(gain);
  assign product  = din_ext * gain_ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    gate_d  = gate;
    dout_d  = product[ENV_BITS +: DATA_BITS];

    if (rise) begin
      state_d = ST_ATTACK;
    end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                          state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else if (sample_tick) begin
      unique case (state_q)
        ST_IDLE: acc_d = acc_q;
        ST_ATTACK: begin
          if (sum_att >= ACC_MAX) begin
            acc_d   = ACC_MAX[ACC_BITS-1:0];
            state_d = ST_DECAY;
          end else begin
            acc_d = sum_att[ACC_BITS-1:0];
          end
        end
        ST_DECAY: begin
          if (diff_dec[ACC_BITS] || (diff_dec[ACC_BITS-1:0] <= sus_acc)) begin
            acc_d   = sus_acc;
            state_d = ST_SUSTAIN;
          end else begin
            acc_d = diff_dec[ACC_BITS-1:0];
          end
        end
        ST_SUSTAIN: acc_d = sus_acc;
        ST_RELEASE: begin
          if (diff_rel[ACC_BITS] || (diff_rel[ACC_BITS-1:0] == '0)) begin
            acc_d   = '0;
            state_d = ST_IDLE;
          end else begin
            acc_d = diff_rel[ACC_BITS-1:0];
          end
        end
        default: begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      gate_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      gate_q  <= gate_d;
      dout_q  <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign env_out   = env;
  assign state_out = state_q;

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Per-voice amplitude envelope stage sitting directly upstream of the channel mixer. It takes one raw signed oscillator sample stream and a note gate, and runs an attack/decay/sustain/release state machine stepped on the audio sample strobe. It outputs the envelope-scaled signed sample that drives one mixer channel input.

Parameters:
DATA_BITS, 12, width of signed sample in/out; must match the mixer DATA_BITS
ENV_BITS, 8, width of the envelope level applied as gain
ACC_BITS, 16, envelope accumulator width; ACC_BITS > ENV_BITS

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  one-clk strobe per audio sample; the envelope steps only on this strobe
gate  input  1  note on (1) / off (0), level-sensitive, sampled every clk
attack_rate  input  ACC_BITS  accumulator increment per tick in ATTACK
decay_rate  input  ACC_BITS  accumulator decrement per tick in DECAY
release_rate  input  ACC_BITS  accumulator decrement per tick in RELEASE
sustain_level  input  ENV_BITS  sustain envelope level
din  input  DATA_BITS signed  raw oscillator sample
dout  output  DATA_BITS signed  scaled sample to mixer channel
env_out  output  ENV_BITS  current envelope level (acc top ENV_BITS)
state_out  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, gate_q=0, dout=0, env_out=0, state_out=0.
- Single clock domain. Synchronous logic runs on posedge clk.
- Edge detect: rise = gate & ~gate_q; fall = ~gate & gate_q. gate_q is registered every clk.
- Priority per clk:
  1. rise -> ATTACK from any state. This is a retrigger: acc is NOT cleared and continues from its current value.
  2. fall while in ATTACK/DECAY/SUSTAIN -> RELEASE. A fall in IDLE or RELEASE is ignored.
  3. Otherwise, on sample_tick, step acc per the current state.
  - In a cycle where an edge changes state, acc does not step, even if sample_tick=1.
- ACC_MAX = 2^ACC_BITS-1.
- sus_acc = {sustain_level, (ACC_BITS-ENV_BITS) zeros}.
- Tick steps (arithmetic is ACC_BITS+1 wide, no wrap):
  - IDLE: acc held.
  - ATTACK: acc+attack_rate. If the result is >= ACC_MAX, acc=ACC_MAX and go to DECAY.
  - DECAY: acc-decay_rate. If the result is <= sus_acc (including underflow), acc=sus_acc and go to SUSTAIN.
  - SUSTAIN: acc=sus_acc every tick, so live sustain_level changes are tracked.
  - RELEASE: acc-release_rate. If the result is <= 0, acc=0 and go to IDLE.
  - A zero rate holds acc in that state indefinitely. This is legal, not an error.
- Entering DECAY with acc already <= sus_acc: the first tick clamps acc to sus_acc and goes to SUSTAIN.
- env = acc[ACC_BITS-1 -: ENV_BITS]. env_out and state_out are registered and reflect post-update values.
- Scaling: product = din * signed({1'b0, env}), DATA_BITS+ENV_BITS+1 bits wide. dout = product >>> ENV_BITS, truncated to DATA_BITS. No overflow is possible because gain < 1.
- dout is registered every clk, not only on ticks. Latency from din to dout is 1 clk, using the env value registered in the previous cycle.
- env=0 gives dout=0. Arithmetic shift floors toward negative infinity.
- Gate held high through reset release: gate_q=0 after reset, so a rise is seen on the first clk and the block enters ATTACK.
- Reset asserted mid-envelope: all state is cleared immediately (async); no release tail.

Test Plan:
- Reset with gate=1, attack_rate=0x1000, decay_rate=0x0800, sustain_level=0x80, sample_tick every 4 clk; release reset -> ATTACK 1 clk later; acc saturates to 0xFFFF on tick 16 (env_out=0xFF) -> DECAY; tick 32 clamps to 0x8000 -> SUSTAIN, env_out=0x80.
- In SUSTAIN, change sustain_level 0x80 -> 0x40 -> env_out=0x40 on the next tick; state stays SUSTAIN.
- Gate fall in SUSTAIN at acc=0x8000, release_rate=0x0100 -> RELEASE; 128 ticks later acc=0, state IDLE, env_out=0.
- Retrigger: gate falls then rises 3 ticks into RELEASE (acc=0x7D00) -> ATTACK with acc continuing from 0x7D00, not 0; rise coincident with sample_tick -> no step that cycle.
- Scaling with env=0xFF: din=2047 -> dout=2039; din=-2048 -> dout=-2040; env=0x80, din=-3 -> dout=-2 (floor); env=0 -> dout=0; 1-clk latency checked.
- Async reset pulsed mid-ATTACK, between clk edges -> dout, env_out, state_out are 0 immediately, without waiting for an edge.
